uart_txrx: RTL and testbench

Parametrised full-duplex UART core: a transmitter with a ready/start handshake and a receiver with a mid-bit sampler. It supports configurable data width, stop bits and bit period, and adds optional parity. It replaces the fixed 8-bit UART in the serial subsystem and connects directly to the `tx`/`rx` pads on one side and a byte-stream producer/consumer on the other.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_txrx_if.sv | 27 ++
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uart_txrx.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_txrx.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_txrx block.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: TX/RX state enums, line-level constants, parity helper.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  // Payload is zero-extended into 16 bits; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_txrx_if.sv
// Byte-stream and pad signals of the uart_txrx block.
// Latency: n/a (wiring only). Backpressure: tx_ready gates tx_start; RX has none.
// Modports: master = producer/consumer + rx pad driver, slave = the UART core.
interface uart_txrx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 tx;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_start, tx_data, rx,
    input  tx_ready, tx_done, tx, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_start, tx_data, rx,
    output tx_ready, tx_done, tx, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLK_DIV-1 and pulses o_tick on the last count.
// Latency: o_tick CLK_DIV cycles after a full load, CLK_DIV/2 after a half load.
// Backpressure: none; i_en freezes the count, i_load overrides i_en.
// Ports: i_clk, i_rst (sync, high), i_load, i_half, i_en in; o_tick out.
module uart_bit_timer #(
  parameter int CLK_DIV = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_half,
  input  logic i_en,
  output logic o_tick
);
  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  // Starting here leaves exactly CLK_DIV/2 counts before the wrap.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV - CLK_DIV / 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_half ? CNT_HALF : '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART: ready/start transmitter and mid-bit sampling receiver.
// Latency: tx falls 1 cycle after accept; rx_valid 1 cycle after first stop sample.
// Backpressure: TX accepts only while tx_ready; RX has none (rx_valid is a pulse).
// Ports: i_clk, i_rst (sync, high), bus (uart_txrx_if.slave).
// Optional feature macro: UART_PARITY_EN (adds parity bit, drives rx_parity_err).
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  uart_txrx_if.slave   bus
);
  localparam int             BCW       = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  if (CLK_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_txrx: illegal parameter set");
  end

  // ---------------------------------------------------------------- TX
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [DATA_BITS-1:0] r_tx_shreg;
  logic [BCW-1:0]       r_tx_bitcnt;
  logic                 w_tx_accept;
  logic                 w_tx_tick;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  assign w_tx_accept = (r_tx_state == TX_IDLE) && bus.tx_start;

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_tx_accept),
    .i_half (1'b0),
    .i_en   (r_tx_state != TX_IDLE),
    .o_tick (w_tx_tick)
  );

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    bus.tx         = IDLE_LEVEL;
    bus.tx_ready   = 1'b0;
    bus.tx_done    = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        bus.tx_ready = 1'b1;
        if (bus.tx_start) w_tx_state_nxt = TX_START;
      end
      TX_START: begin
        bus.tx = START_BIT;
        if (w_tx_tick) w_tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        bus.tx = r_tx_shreg[0];
        if (w_tx_tick && r_tx_bitcnt == LAST_DATA) begin
`ifdef UART_PARITY_EN
          w_tx_state_nxt = TX_PARITY;
`else
          w_tx_state_nxt = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        bus.tx = r_tx_par;
        if (w_tx_tick) w_tx_state_nxt = TX_STOP;
      end
`endif
      TX_STOP: begin
        bus.tx = STOP_BIT;
        if (w_tx_tick && r_tx_bitcnt == LAST_STOP) begin
          bus.tx_done    = 1'b1;
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state  <= TX_IDLE;
      r_tx_shreg  <= '0;
      r_tx_bitcnt <= '0;
`ifdef UART_PARITY_EN
      r_tx_par    <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_accept) begin
        r_tx_shreg  <= bus.tx_data;
        r_tx_bitcnt <= '0;
`ifdef UART_PARITY_EN
        r_tx_par    <= parity_bit(16'(bus.tx_data), 1'(PARITY_ODD));
`endif
      end else if (w_tx_tick) begin
        // Counter restarts whenever the FSM moves on, so DATA and STOP share it.
        r_tx_bitcnt <= (w_tx_state_nxt != r_tx_state) ? '0 : r_tx_bitcnt + 1'b1;
        if (r_tx_state == TX_DATA) r_tx_shreg <= r_tx_shreg >> 1;
      end
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  logic [DATA_BITS-1:0] r_rx_shreg;
  logic [BCW-1:0]       r_rx_bitcnt;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rx_frame_err;
  logic                 w_rx_fall;
  logic                 w_rx_load;
  logic                 w_rx_run;
  logic                 w_rx_tick;
`ifdef UART_PARITY_EN
  logic                 r_rx_par;
  logic                 r_rx_parity_err;
`endif

  assign w_rx_fall = r_rx_prev && !r_rx_sync;
  assign w_rx_load = (r_rx_state == RX_IDLE) && w_rx_fall;
  assign w_rx_run  = (r_rx_state != RX_IDLE) && (r_rx_state != RX_WAIT_IDLE);

  // Half-period load centres every later sample in its bit.
  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_rx_load),
    .i_half (1'b1),
    .i_en   (w_rx_run),
    .o_tick (w_rx_tick)
  );

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_state_nxt = RX_START;
      RX_START: if (w_rx_tick) w_rx_state_nxt = (r_rx_sync == START_BIT) ? RX_DATA : RX_IDLE;
      RX_DATA: begin
        if (w_rx_tick && r_rx_bitcnt == LAST_DATA) begin
`ifdef UART_PARITY_EN
          w_rx_state_nxt = RX_PARITY;
`else
          w_rx_state_nxt = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (w_rx_tick) w_rx_state_nxt = RX_STOP;
`endif
      // Only the first stop bit is checked; a low stop bit means a break.
      RX_STOP:      if (w_rx_tick) w_rx_state_nxt = (r_rx_sync == STOP_BIT) ? RX_IDLE : RX_WAIT_IDLE;
      RX_WAIT_IDLE: if (r_rx_sync == IDLE_LEVEL) w_rx_state_nxt = RX_IDLE;
      default:      w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_state      <= RX_IDLE;
      r_rx_meta       <= IDLE_LEVEL;
      r_rx_sync       <= IDLE_LEVEL;
      r_rx_prev       <= IDLE_LEVEL;
      r_rx_shreg      <= '0;
      r_rx_bitcnt     <= '0;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par        <= 1'b0;
      r_rx_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_meta  <= bus.rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_rx_valid <= 1'b0;
      if (w_rx_load) begin
        r_rx_bitcnt <= '0;
      end else if (w_rx_tick) begin
        r_rx_bitcnt <= (w_rx_state_nxt != r_rx_state) ? '0 : r_rx_bitcnt + 1'b1;
        case (r_rx_state)
          RX_DATA: r_rx_shreg <= {r_rx_sync, r_rx_shreg[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
          RX_PARITY: r_rx_par <= r_rx_sync;
`endif
          RX_STOP: begin
            r_rx_valid     <= 1'b1;
            r_rx_data      <= r_rx_shreg;
            r_rx_frame_err <= (r_rx_sync != STOP_BIT);
`ifdef UART_PARITY_EN
            r_rx_parity_err <= (r_rx_par != parity_bit(16'(r_rx_shreg), 1'(PARITY_ODD)));
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_frame_err = r_rx_frame_err;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = r_rx_parity_err;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: reset, TX waveform, loopback, RX error cases.
// Build with UART_PARITY_EN defined for the 7-bit even-parity variant.
module tb_uart_txrx;
  localparam int CLK_DIV = 16;
`ifdef UART_PARITY_EN
  localparam int DW = 7;
`else
  localparam int DW = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  logic r_loop;
  logic r_rx_drv;

  always #5 clk = ~clk;

  uart_txrx_if #(.DATA_BITS(DW)) u_if ();
  assign u_if.rx = r_loop ? u_if.tx : r_rx_drv;

  uart_txrx #(
    .CLK_DIV    (CLK_DIV),
    .DATA_BITS  (DW),
    .STOP_BITS  (1),
    .PARITY_ODD (0)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Capture of rx_valid events seen by step().
  int            rv_cnt;
  logic [DW-1:0] rv_data [4];
  logic          rv_ferr [4];
  logic          rv_perr [4];

  // Frame on tx, index 0 = start bit.
`ifdef UART_PARITY_EN
  logic [DW-1:0] tx_val    = 7'h55;
  logic [9:0]    exp_frame = 10'b1010101010;  // 0,1010101 LSB first, parity 0, stop 1
`else
  logic [DW-1:0] tx_val    = 8'hA5;
  logic [9:0]    exp_frame = 10'b1101001010;  // 0,1,0,1,0,0,1,0,1,1
`endif

  task automatic step();
    @(posedge clk);
    #1;
    if (u_if.rx_valid) begin
      if (rv_cnt < 4) begin
        rv_data[rv_cnt] = u_if.rx_data;
        rv_ferr[rv_cnt] = u_if.rx_frame_err;
        rv_perr[rv_cnt] = u_if.rx_parity_err;
      end
      rv_cnt++;
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    r_rx_drv = v;
    repeat (n) step();
  endtask

  // Well-formed frame with even parity when parity is compiled in.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_v);
    drive_bit(1'b0, CLK_DIV);
    for (int i = 0; i < DW; i++) drive_bit(d[i], CLK_DIV);
`ifdef UART_PARITY_EN
    drive_bit(^d, CLK_DIV);
`endif
    drive_bit(stop_v, CLK_DIV);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    n_checks++;
    if (u_if.tx !== 1'b1) $display("FAIL reset_tx got=%b exp=1", u_if.tx); else n_pass++;
    n_checks++;
    if (u_if.tx_ready !== 1'b1) $display("FAIL reset_tx_ready got=%b exp=1", u_if.tx_ready); else n_pass++;
    n_checks++;
    if (u_if.tx_done !== 1'b0) $display("FAIL reset_tx_done got=%b exp=0", u_if.tx_done); else n_pass++;
    n_checks++;
    if (u_if.rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", u_if.rx_valid); else n_pass++;
    n_checks++;
    if (u_if.rx_data !== '0) $display("FAIL reset_rx_data got=%h exp=0", u_if.rx_data); else n_pass++;
    n_checks++;
    if ({u_if.rx_frame_err, u_if.rx_parity_err} !== 2'b00)
      $display("FAIL reset_err_flags got=%b exp=00", {u_if.rx_frame_err, u_if.rx_parity_err});
    else n_pass++;
    rv_cnt = 0;
    bad    = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (u_if.tx !== 1'b1 || u_if.tx_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL idle_tx_ready bad_cycles=%0d exp=0", bad); else n_pass++;
    n_checks++;
    if (rv_cnt != 0) $display("FAIL idle_rx_valid got=%0d exp=0", rv_cnt); else n_pass++;
  endtask

  task automatic test_tx_basic();
    int done_cnt;
    int done_cyc;
    u_if.tx_data  = tx_val;
    u_if.tx_start = 1'b1;
    n_checks++;
    if (u_if.tx_ready !== 1'b1) $display("FAIL tx_ready_pre got=%b exp=1", u_if.tx_ready); else n_pass++;
    step();
    u_if.tx_start = 1'b0;
    n_checks++;
    if (u_if.tx_ready !== 1'b0) $display("FAIL tx_ready_busy got=%b exp=0", u_if.tx_ready); else n_pass++;
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 1; k <= 160; k++) begin
      n_checks++;
      if (u_if.tx !== exp_frame[(k-1)/16])
        $display("FAIL tx_bit cyc=%0d got=%b exp=%b", k, u_if.tx, exp_frame[(k-1)/16]);
      else n_pass++;
      if (u_if.tx_done) begin
        done_cnt++;
        done_cyc = k;
      end
      step();
    end
    if (u_if.tx_done) done_cnt++;
    n_checks++;
    if (done_cyc != 160) $display("FAIL tx_done_cycle got=%0d exp=160", done_cyc); else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL tx_done_pulses got=%0d exp=1", done_cnt); else n_pass++;
    n_checks++;
    if (u_if.tx_ready !== 1'b1) $display("FAIL tx_ready_after got=%b exp=1", u_if.tx_ready); else n_pass++;
    n_checks++;
    if (u_if.tx !== 1'b1) $display("FAIL tx_idle_after got=%b exp=1", u_if.tx); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    u_if.tx_data  = tx_val;
    u_if.tx_start = 1'b1;
    step();
    u_if.tx_start = 1'b0;
    repeat (40) step();
    n_checks++;
    if (u_if.tx !== 1'b0) $display("FAIL midframe_tx_pre got=%b exp=0", u_if.tx); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++;
    if (u_if.tx !== 1'b1) $display("FAIL midframe_tx_abort got=%b exp=1", u_if.tx); else n_pass++;
    n_checks++;
    if (u_if.tx_ready !== 1'b1) $display("FAIL midframe_tx_ready got=%b exp=1", u_if.tx_ready); else n_pass++;
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
    int            acc_cyc [3];
    int            idx;
    logic          acc_now;
    vals[0] = DW'(8'h00);
`ifdef UART_PARITY_EN
    vals[1] = 7'h7F;
`else
    vals[1] = 8'hFF;
`endif
    vals[2] = DW'(8'h3C);
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    rv_cnt = 0;
    r_loop = 1'b1;
    idx    = 0;
    u_if.tx_data  = vals[0];
    u_if.tx_start = 1'b1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      acc_now = u_if.tx_start && u_if.tx_ready;
      step();
      if (acc_now) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) u_if.tx_data = vals[idx];
        else u_if.tx_start = 1'b0;
      end
      if (idx == 3 && rv_cnt >= 3) break;
    end
    u_if.tx_start = 1'b0;
    repeat (CLK_DIV) step();
    r_loop = 1'b0;
    n_checks++;
    if (rv_cnt != 3) $display("FAIL loop_rx_count got=%0d exp=3", rv_cnt); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rv_data[i] !== vals[i]) $display("FAIL loop_rx_data idx=%0d got=%h exp=%h", i, rv_data[i], vals[i]);
      else n_pass++;
      n_checks++;
      if ({rv_ferr[i], rv_perr[i]} !== 2'b00)
        $display("FAIL loop_rx_err idx=%0d got=%b exp=00", i, {rv_ferr[i], rv_perr[i]});
      else n_pass++;
    end
    n_checks++;
    if (acc_cyc[1] - acc_cyc[0] != 161) $display("FAIL loop_gap1 got=%0d exp=161", acc_cyc[1] - acc_cyc[0]); else n_pass++;
    n_checks++;
    if (acc_cyc[2] - acc_cyc[1] != 161) $display("FAIL loop_gap2 got=%0d exp=161", acc_cyc[2] - acc_cyc[1]); else n_pass++;
  endtask

  task automatic test_frame_error();
    rv_cnt = 0;
    drive_bit(1'b1, 2 * CLK_DIV);
    drive_bit(1'b0, CLK_DIV);
    for (int i = 0; i < DW; i++) drive_bit(8'h5A >> i, CLK_DIV);
`ifdef UART_PARITY_EN
    drive_bit(1'b0, CLK_DIV);  // 1011010 has four ones: even parity 0
`endif
    drive_bit(1'b0, 51 * CLK_DIV);  // low stop bit, then 50 more bit periods of break
    n_checks++;
    if (rv_cnt != 1) $display("FAIL ferr_count got=%0d exp=1", rv_cnt); else n_pass++;
    n_checks++;
    if (rv_ferr[0] !== 1'b1) $display("FAIL ferr_flag got=%b exp=1", rv_ferr[0]); else n_pass++;
    n_checks++;
    if (rv_data[0] !== DW'(8'h5A)) $display("FAIL ferr_data got=%h exp=5a", rv_data[0]); else n_pass++;
    drive_bit(1'b1, 2 * CLK_DIV);
    send_frame(DW'(8'h33), 1'b1);
    drive_bit(1'b1, 2 * CLK_DIV);
    n_checks++;
    if (rv_cnt != 2) $display("FAIL ferr_recover_count got=%0d exp=2", rv_cnt); else n_pass++;
    n_checks++;
    if (rv_data[1] !== DW'(8'h33)) $display("FAIL ferr_recover_data got=%h exp=33", rv_data[1]); else n_pass++;
    n_checks++;
    if (rv_ferr[1] !== 1'b0) $display("FAIL ferr_recover_flag got=%b exp=0", rv_ferr[1]); else n_pass++;
  endtask

  task automatic test_false_start();
    rv_cnt = 0;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2 * CLK_DIV);
    n_checks++;
    if (rv_cnt != 0) $display("FAIL glitch_no_valid got=%0d exp=0", rv_cnt); else n_pass++;
    send_frame(DW'(8'h4B), 1'b1);
    drive_bit(1'b1, 2 * CLK_DIV);
    n_checks++;
    if (rv_cnt != 1) $display("FAIL glitch_frame_count got=%0d exp=1", rv_cnt); else n_pass++;
    n_checks++;
    if (rv_data[0] !== DW'(8'h4B)) $display("FAIL glitch_frame_data got=%h exp=4b", rv_data[0]); else n_pass++;
    n_checks++;
    if ({rv_ferr[0], rv_perr[0]} !== 2'b00)
      $display("FAIL glitch_frame_err got=%b exp=00", {rv_ferr[0], rv_perr[0]});
    else n_pass++;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [6:0] d55 = 7'h55;
    logic [6:0] d13 = 7'h13;
    rv_cnt = 0;
    drive_bit(1'b0, CLK_DIV);
    for (int i = 0; i < 7; i++) drive_bit(d55[i], CLK_DIV);
    drive_bit(1'b1, CLK_DIV);  // correct even parity is 0; flipped
    drive_bit(1'b1, 3 * CLK_DIV);
    drive_bit(1'b0, CLK_DIV);
    for (int i = 0; i < 7; i++) drive_bit(d13[i], CLK_DIV);
    drive_bit(1'b1, CLK_DIV);  // three ones: even parity 1
    drive_bit(1'b1, 3 * CLK_DIV);
    n_checks++;
    if (rv_cnt != 2) $display("FAIL par_count got=%0d exp=2", rv_cnt); else n_pass++;
    n_checks++;
    if (rv_perr[0] !== 1'b1) $display("FAIL par_err_flag got=%b exp=1", rv_perr[0]); else n_pass++;
    n_checks++;
    if (rv_data[0] !== 7'h55) $display("FAIL par_err_data got=%h exp=55", rv_data[0]); else n_pass++;
    n_checks++;
    if (rv_ferr[0] !== 1'b0) $display("FAIL par_err_ferr got=%b exp=0", rv_ferr[0]); else n_pass++;
    n_checks++;
    if (rv_perr[1] !== 1'b0) $display("FAIL par_ok_flag got=%b exp=0", rv_perr[1]); else n_pass++;
    n_checks++;
    if (rv_data[1] !== 7'h13) $display("FAIL par_ok_data got=%h exp=13", rv_data[1]); else n_pass++;
  endtask
`endif

  initial begin
    rst           = 1'b1;
    r_loop        = 1'b0;
    r_rx_drv      = 1'b1;
    rv_cnt        = 0;
    u_if.tx_start = 1'b0;
    u_if.tx_data  = '0;
    for (int i = 0; i < 4; i++) begin
      rv_data[i] = '0;
      rv_ferr[i] = 1'b0;
      rv_perr[i] = 1'b0;
    end
    test_reset();
    test_tx_basic();
    test_reset_midframe();
    test_back_to_back();
    test_frame_error();
    test_false_start();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
